// File: rtl/btb_pred.sv
// btb_pred: N-way fully-associative branch target buffer with per-entry
// saturating direction counters.
//
// Fetch looks up lkp_pc_i and gets a registered prediction one cycle later.
// The branch unit trains the buffer with resolved branches (upd_*). flush_i
// invalidates every entry and rewinds the replacement pointer.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush_i           invalidate all entries
//   lkp_v_i/lkp_pc_i  lookup request
//   pred_v_o          prediction valid (hit on previous cycle's lookup)
//   pred_taken_o      predicted taken (counter MSB)
//   pc_pred_o         predicted target, low PC_LSB bits zero
//   upd_v_i/upd_pc_i/upd_target_i/upd_taken_i  resolved branch update
//
// Optional macro PRED_BYPASS_EN: a lookup that matches a same-cycle update
// returns post-update state instead of pre-update state.
module btb_pred #(
  parameter int unsigned PRED_SIZE = 8,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned PC_LSB    = 2,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            lkp_v_i,
  input  logic [XLEN-1:0] lkp_pc_i,
  output logic            pred_v_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pc_pred_o,
  input  logic            upd_v_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);

  localparam int unsigned TAG_W = XLEN - PC_LSB;
  localparam int unsigned PTR_W = $clog2(PRED_SIZE);
  localparam logic [CNT_W-1:0] CNT_WNT  = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT   = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PRED_SIZE - 1);

  logic             valid_q [PRED_SIZE];
  logic [TAG_W-1:0] tag_q   [PRED_SIZE];
  logic [TAG_W-1:0] tgt_q   [PRED_SIZE];
  logic [CNT_W-1:0] cnt_q   [PRED_SIZE];
  logic [PTR_W-1:0] rptr_q;

  logic [TAG_W-1:0] lkp_tag_c, upd_tag_c, upd_tgt_c;
  logic             lkp_hit_c, upd_hit_c, free_v_c;
  logic [PTR_W-1:0] lkp_idx_c, upd_idx_c, free_idx_c, victim_c;
  logic [CNT_W-1:0] cnt_upd_c;
  logic             pv_c, pt_c;
  logic [TAG_W-1:0] ptgt_c;
  logic             lsb_unused;

  assign lkp_tag_c  = lkp_pc_i[XLEN-1:PC_LSB];
  assign upd_tag_c  = upd_pc_i[XLEN-1:PC_LSB];
  assign upd_tgt_c  = upd_target_i[XLEN-1:PC_LSB];
  assign lsb_unused = ^{lkp_pc_i[PC_LSB-1:0], upd_pc_i[PC_LSB-1:0],
                        upd_target_i[PC_LSB-1:0]};

  // Tag match for lookup and update, plus lowest free slot; descending loops
  // leave the lowest matching index as the winner.
  always_comb begin
    lkp_hit_c  = 1'b0;
    lkp_idx_c  = '0;
    upd_hit_c  = 1'b0;
    upd_idx_c  = '0;
    free_v_c   = 1'b0;
    free_idx_c = '0;
    for (int i = int'(PRED_SIZE) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lkp_tag_c)) begin
        lkp_hit_c = 1'b1;
        lkp_idx_c = PTR_W'(i);
      end
      if (valid_q[i] && (tag_q[i] == upd_tag_c)) begin
        upd_hit_c = 1'b1;
        upd_idx_c = PTR_W'(i);
      end
      if (!valid_q[i]) begin
        free_v_c   = 1'b1;
        free_idx_c = PTR_W'(i);
      end
    end
  end

  assign victim_c = free_v_c ? free_idx_c : rptr_q;

  // Saturating counter step for an update that hits.
  always_comb begin
    cnt_upd_c = cnt_q[upd_idx_c];
    if (upd_taken_i && (cnt_q[upd_idx_c] != CNT_MAX)) begin
      cnt_upd_c = cnt_q[upd_idx_c] + CNT_W'(1);
    end else if (!upd_taken_i && (cnt_q[upd_idx_c] != '0)) begin
      cnt_upd_c = cnt_q[upd_idx_c] - CNT_W'(1);
    end
  end

  // Prediction from current state, optionally overridden by a same-PC update.
  always_comb begin
    pv_c   = lkp_hit_c;
    pt_c   = lkp_hit_c & cnt_q[lkp_idx_c][CNT_W-1];
    ptgt_c = lkp_hit_c ? tgt_q[lkp_idx_c] : '0;
`ifdef PRED_BYPASS_EN
    if (upd_v_i && !flush_i && (upd_tag_c == lkp_tag_c)) begin
      if (upd_hit_c) begin
        pv_c   = 1'b1;
        pt_c   = cnt_upd_c[CNT_W-1];
        ptgt_c = upd_taken_i ? upd_tgt_c : tgt_q[upd_idx_c];
      end else if (upd_taken_i) begin
        pv_c   = 1'b1;
        pt_c   = 1'b1;
        ptgt_c = upd_tgt_c;
      end else begin
        pv_c   = 1'b0;
        pt_c   = 1'b0;
        ptgt_c = '0;
      end
    end
`endif
  end

  // Entry state, replacement pointer and registered prediction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(PRED_SIZE); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
      end
      rptr_q       <= '0;
      pred_v_o     <= 1'b0;
      pred_taken_o <= 1'b0;
      pc_pred_o    <= '0;
    end else begin
      pred_v_o     <= lkp_v_i & pv_c;
      pred_taken_o <= lkp_v_i & pt_c;
      pc_pred_o    <= lkp_v_i ? {ptgt_c, {PC_LSB{1'b0}}} : '0;
      if (flush_i) begin
        for (int i = 0; i < int'(PRED_SIZE); i++) begin
          valid_q[i] <= 1'b0;
        end
        rptr_q <= '0;
      end else if (upd_v_i) begin
        if (upd_hit_c) begin
          cnt_q[upd_idx_c] <= cnt_upd_c;
          if (upd_taken_i) begin
            tgt_q[upd_idx_c] <= upd_tgt_c;
          end
        end else if (upd_taken_i) begin
          valid_q[victim_c] <= 1'b1;
          tag_q[victim_c]   <= upd_tag_c;
          tgt_q[victim_c]   <= upd_tgt_c;
          cnt_q[victim_c]   <= CNT_WT;
          // Pointer moves only when it supplied the victim (table full).
          if (!free_v_c) begin
            rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_pred.sv
// Self-checking bench for btb_pred: directed scenarios plus randomized
// traffic against a table-level reference model.
module tb_btb_pred;

  localparam int unsigned PRED_SIZE = 8;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned PC_LSB    = 2;
  localparam int unsigned XLEN      = 32;
  localparam int          CNT_HALF  = 1 << (CNT_W - 1);
  localparam int          CNT_TOP   = (1 << CNT_W) - 1;
  localparam logic [31:0] LSB_MASK  = ~32'((1 << PC_LSB) - 1);

  logic            clk = 1'b0;
  logic            reset, flush_i, lkp_v_i, upd_v_i, upd_taken_i;
  logic [XLEN-1:0] lkp_pc_i, upd_pc_i, upd_target_i;
  logic            pred_v_o, pred_taken_o;
  logic [XLEN-1:0] pc_pred_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: entries by index, as the buffer is described.
  bit          m_valid [PRED_SIZE];
  logic [31:0] m_pc    [PRED_SIZE];
  logic [31:0] m_tgt   [PRED_SIZE];
  int          m_cnt   [PRED_SIZE];
  int          m_rptr;
  logic        exp_v, exp_tk;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  btb_pred #(.PRED_SIZE(PRED_SIZE), .CNT_W(CNT_W), .PC_LSB(PC_LSB), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .lkp_v_i(lkp_v_i), .lkp_pc_i(lkp_pc_i),
    .pred_v_o(pred_v_o), .pred_taken_o(pred_taken_o), .pc_pred_o(pc_pred_o),
    .upd_v_i(upd_v_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
    .upd_taken_i(upd_taken_i)
  );

  function automatic bit same_line(logic [31:0] a, logic [31:0] b);
    return (a & LSB_MASK) == (b & LSB_MASK);
  endfunction

  function automatic int m_find(logic [31:0] pc);
    for (int i = 0; i < int'(PRED_SIZE); i++)
      if (m_valid[i] && same_line(m_pc[i], pc)) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(PRED_SIZE); i++) begin
      m_valid[i] = 0; m_pc[i] = 0; m_tgt[i] = 0; m_cnt[i] = CNT_HALF - 1;
    end
    m_rptr = 0;
  endtask

  task automatic m_lookup(logic lv, logic [31:0] pc);
    int idx;
    idx = m_find(pc);
    exp_v  = lv && (idx >= 0);
    exp_tk = exp_v && (m_cnt[idx] >= CNT_HALF);
    exp_pc = exp_v ? m_tgt[idx] : 32'h0;
  endtask

  task automatic m_update(logic uv, logic [31:0] pc, logic [31:0] tg, logic tk, logic fl);
    int idx, vic;
    if (fl) begin
      for (int i = 0; i < int'(PRED_SIZE); i++) m_valid[i] = 0;
      m_rptr = 0;
    end else if (uv) begin
      idx = m_find(pc);
      if (idx >= 0) begin
        m_cnt[idx] = tk ? ((m_cnt[idx] < CNT_TOP) ? m_cnt[idx] + 1 : CNT_TOP)
                        : ((m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0);
        if (tk) m_tgt[idx] = tg & LSB_MASK;
      end else if (tk) begin
        vic = -1;
        for (int i = int'(PRED_SIZE) - 1; i >= 0; i--) if (!m_valid[i]) vic = i;
        if (vic < 0) begin
          vic = m_rptr;
          m_rptr = (m_rptr + 1) % int'(PRED_SIZE);
        end
        m_valid[vic] = 1; m_pc[vic] = pc; m_tgt[vic] = tg & LSB_MASK;
        m_cnt[vic] = CNT_HALF;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic apply(logic lv, logic [31:0] lpc, logic uv, logic [31:0] upc,
                       logic [31:0] utg, logic ut, logic fl);
    lkp_v_i = lv; lkp_pc_i = lpc; upd_v_i = uv; upd_pc_i = upc;
    upd_target_i = utg; upd_taken_i = ut; flush_i = fl;
`ifdef PRED_BYPASS_EN
    if (lv && uv && !fl && same_line(lpc, upc)) begin
      m_update(uv, upc, utg, ut, fl); m_lookup(lv, lpc);
    end else begin
      m_lookup(lv, lpc); m_update(uv, upc, utg, ut, fl);
    end
`else
    m_lookup(lv, lpc); m_update(uv, upc, utg, ut, fl);
`endif
    @(posedge clk); #1;
  endtask

  task automatic lookup(logic [31:0] pc);
    apply(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic train(logic [31:0] pc, logic [31:0] tg, logic tk);
    apply(1'b0, 32'h0, 1'b1, pc, tg, tk, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_i = 0; lkp_v_i = 1; lkp_pc_i = 32'h100;
    upd_v_i = 1; upd_pc_i = 32'h100; upd_target_i = 32'h200; upd_taken_i = 1;
    repeat (2) @(posedge clk);
    #1; m_reset();
    n_vec++;
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== 34'h0) begin
      n_err++; $display("FAIL reset_out got v=%0b t=%0b pc=%h want 0", pred_v_o, pred_taken_o, pc_pred_o);
    end
    reset = 1'b0;
    lookup(32'h100);
    n_vec++;
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== 34'h0) begin
      n_err++; $display("FAIL reset_lookup got v=%0b t=%0b pc=%h want 0", pred_v_o, pred_taken_o, pc_pred_o);
    end
  endtask

  task automatic test_train();
    train(32'h100, 32'h200, 1'b1);
    lookup(32'h100);
    n_vec++;
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== {2'b11, 32'h200}) begin
      n_err++; $display("FAIL alloc_hit got v=%0b t=%0b pc=%h want 1 1 200", pred_v_o, pred_taken_o, pc_pred_o);
    end
    repeat (3) train(32'h100, 32'h0, 1'b0);
    lookup(32'h100);
    n_vec++;
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== {2'b10, 32'h200}) begin
      n_err++; $display("FAIL nt_train got v=%0b t=%0b pc=%h want 1 0 200", pred_v_o, pred_taken_o, pc_pred_o);
    end
    train(32'h100, 32'h0, 1'b0);
    train(32'h100, 32'h204, 1'b1);
    lookup(32'h100);
    n_vec++;
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== {2'b10, 32'h204}) begin
      n_err++; $display("FAIL sat_low got v=%0b t=%0b pc=%h want 1 0 204", pred_v_o, pred_taken_o, pc_pred_o);
    end
    train(32'h100, 32'h208, 1'b1);
    lookup(32'h103);
    n_vec++;
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== {2'b11, 32'h208}) begin
      n_err++; $display("FAIL retrain got v=%0b t=%0b pc=%h want 1 1 208", pred_v_o, pred_taken_o, pc_pred_o);
    end
  endtask

  task automatic test_nt_miss();
    train(32'h300, 32'h500, 1'b0);
    lookup(32'h300);
    n_vec++;
    if (pred_v_o !== 1'b0) begin
      n_err++; $display("FAIL nt_miss got v=%0b want 0", pred_v_o);
    end
  endtask

  task automatic test_replace();
    test_reset();
    for (int k = 0; k < 8; k++) train(32'h1000 + 32'(4 * k), 32'h3000 + 32'(4 * k), 1'b1);
    train(32'h2000, 32'h4000, 1'b1);
    lookup(32'h1000);
    n_vec++;
    if (pred_v_o !== 1'b0) begin
      n_err++; $display("FAIL evict_e0 got v=%0b want 0", pred_v_o);
    end
    lookup(32'h1004);
    n_vec++;
    if ({pred_v_o, pc_pred_o} !== {1'b1, 32'h3004}) begin
      n_err++; $display("FAIL keep_e1 got v=%0b pc=%h want 1 3004", pred_v_o, pc_pred_o);
    end
    lookup(32'h2000);
    n_vec++;
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== {2'b11, 32'h4000}) begin
      n_err++; $display("FAIL new_e0 got v=%0b t=%0b pc=%h want 1 1 4000", pred_v_o, pred_taken_o, pc_pred_o);
    end
    train(32'h2004, 32'h4004, 1'b1);
    lookup(32'h1004);
    n_vec++;
    if (pred_v_o !== 1'b0) begin
      n_err++; $display("FAIL rptr_adv got v=%0b want 0", pred_v_o);
    end
  endtask

  task automatic test_flush();
    apply(1'b1, 32'h1008, 1'b1, 32'h400, 32'h800, 1'b1, 1'b1);
    n_vec++;
    if ({pred_v_o, pc_pred_o} !== {1'b1, 32'h3008}) begin
      n_err++; $display("FAIL flush_prestate got v=%0b pc=%h want 1 3008", pred_v_o, pc_pred_o);
    end
    lookup(32'h1008);
    n_vec++;
    if (pred_v_o !== 1'b0) begin
      n_err++; $display("FAIL flush_clear got v=%0b want 0", pred_v_o);
    end
    lookup(32'h400);
    n_vec++;
    if (pred_v_o !== 1'b0) begin
      n_err++; $display("FAIL flush_drop got v=%0b want 0", pred_v_o);
    end
    train(32'h700, 32'h900, 1'b1);
    for (int k = 0; k < 8; k++) train(32'h710 + 32'(4 * k), 32'h910, 1'b1);
    lookup(32'h700);
    n_vec++;
    if (pred_v_o !== 1'b0) begin
      n_err++; $display("FAIL flush_rptr got v=%0b want 0", pred_v_o);
    end
    lookup(32'h710);
    n_vec++;
    if (pred_v_o !== 1'b1) begin
      n_err++; $display("FAIL flush_e1 got v=%0b want 1", pred_v_o);
    end
  endtask

  task automatic test_same_cycle();
    apply(1'b1, 32'h500, 1'b1, 32'h500, 32'h600, 1'b1, 1'b0);
    n_vec++;
`ifdef PRED_BYPASS_EN
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== {2'b11, 32'h600}) begin
      n_err++; $display("FAIL same_cycle got v=%0b t=%0b pc=%h want 1 1 600", pred_v_o, pred_taken_o, pc_pred_o);
    end
`else
    if ({pred_v_o, pred_taken_o, pc_pred_o} !== 34'h0) begin
      n_err++; $display("FAIL same_cycle got v=%0b t=%0b pc=%h want 0", pred_v_o, pred_taken_o, pc_pred_o);
    end
`endif
    lookup(32'h500);
    n_vec++;
    if ({pred_v_o, pc_pred_o} !== {1'b1, 32'h600}) begin
      n_err++; $display("FAIL same_after got v=%0b pc=%h want 1 600", pred_v_o, pc_pred_o);
    end
  endtask

  task automatic test_random();
    logic        lv, uv, ut, fl;
    logic [31:0] lpc, upc, utg;
    for (int n = 0; n < 1500; n++) begin
      lv  = ($urandom_range(0, 3) != 0);
      uv  = ($urandom_range(0, 1) != 0);
      ut  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      lpc = 32'h8000 + 32'($urandom_range(0, 11) * 4) + 32'($urandom_range(0, 3));
      upc = ($urandom_range(0, 3) == 0) ? lpc
            : 32'h8000 + 32'($urandom_range(0, 11) * 4) + 32'($urandom_range(0, 3));
      utg = $urandom;
      apply(lv, lpc, uv, upc, utg, ut, fl);
      n_vec++;
      if ({pred_v_o, pred_taken_o, pc_pred_o} !== {exp_v, exp_tk, exp_pc}) begin
        n_err++;
        $display("FAIL random[%0d] got v=%0b t=%0b pc=%h want v=%0b t=%0b pc=%h",
                 n, pred_v_o, pred_taken_o, pc_pred_o, exp_v, exp_tk, exp_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_nt_miss();
    test_replace();
    test_flush();
    test_same_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btb_pred.md
Name: btb_pred

Overview:
- Parametrised N-way fully-associative branch target buffer with per-entry saturating direction counters.
- Sits between fetch and the branch unit (BU). Fetch looks up the current PC and receives a registered prediction one cycle later.
- BU reports resolved branches to train the buffer. Supports allocation, counter training, target correction and global flush.

Parameters:
- PRED_SIZE, 8: number of entries; any value >= 2; need not be a power of 2.
- CNT_W, 2: saturating counter width; valid range 2..4.
- PC_LSB, 2: low PC bits ignored in tag compare and not stored (instruction alignment).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  invalidate all entries.
- lkp_v_i  in  1  lookup request from fetch.
- lkp_pc_i  in  XLEN  fetch PC to look up.
- pred_v_o  out  1  prediction valid (registered response to the previous cycle's lkp_v_i).
- pred_taken_o  out  1  predicted taken.
- pc_pred_o  out  XLEN  predicted target; low PC_LSB bits are always 0.
- upd_v_i  in  1  BU resolved-branch update valid.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_target_i  in  XLEN  resolved target.
- upd_taken_i  in  1  resolved direction.

Behaviour:
- Entry state: valid, tag = pc[XLEN-1:PC_LSB], target = target[XLEN-1:PC_LSB], counter[CNT_W-1:0]. Replacement pointer rptr is ceil(log2(PRED_SIZE)) bits.
- Reset (clk edge with reset=1):
  - All valid bits = 0; counters = WNT (2^(CNT_W-1)-1); tags and targets = 0; rptr = 0.
  - pred_v_o, pred_taken_o and pc_pred_o = 0.
  - reset has priority over every other input.
- Lookup hit: valid entry whose tag equals lkp_pc_i[XLEN-1:PC_LSB].
- Lookup latency is 1 cycle. On the cycle after lkp_v_i=1:
  - pred_v_o = hit;
  - pred_taken_o = hit & counter MSB;
  - pc_pred_o = hit ? {target,PC_LSB'b0} : 0.
- If lkp_v_i=0, all three outputs are 0 on the next cycle.
- Multiple hits cannot occur by construction. If they do, the lowest index wins.
- Update with upd_v_i=1, entry hit:
  - counter saturating +1 if taken, -1 if not taken;
  - target overwritten only when taken;
  - rptr unchanged.
- Update with upd_v_i=1, entry miss:
  - upd_taken_i=1: allocate. Victim is the lowest-index invalid entry; if all entries are valid, the victim is rptr.
    - Victim gets valid=1, tag and target written, counter = WT (2^(CNT_W-1)).
    - rptr advances by one only when it was the victim; it wraps from PRED_SIZE-1 to 0.
  - upd_taken_i=0: no allocation and no state change.
- flush_i=1: all valid bits cleared and rptr = 0 at the next edge. Counters and targets are left as they are.
  - An update in the same cycle is dropped.
  - A lookup in the same cycle still returns its result from pre-flush state.
- Lookup and update to the same PC in the same cycle: the lookup sees pre-update state, unless the optional feature is enabled.
- The buffer is stateful between updates. No handshake back-pressure exists: every lkp_v_i and upd_v_i is consumed in the cycle it is asserted.

Optional Feature:
- Macro: PRED_BYPASS_EN.
- Defined: when upd_v_i=1 and upd_pc_i matches lkp_pc_i (tag bits) in the same cycle, without flush_i, the registered prediction reflects post-update state.
  - Taken = MSB of the new counter.
  - Target = upd_target_i if taken, else the stored target.
  - A newly allocated entry yields pred_v_o=1, pred_taken_o=1, pc_pred_o=upd_target_i.
  - A not-taken miss yields pred_v_o=0.
- Undefined: no forwarding; the lookup returns pre-update state.

Test Plan:
- Reset, then lookup 0x100 -> next cycle pred_v_o=0, pred_taken_o=0, pc_pred_o=0.
- Update pc=0x100, target=0x200, taken=1; lookup 0x100 the following cycle -> pred_v_o=1, pred_taken_o=1, pc_pred_o=0x200. Three not-taken updates to 0x100 (CNT_W=2) -> counter 00, pred_taken_o=0, pred_v_o=1.
- Not-taken update on unknown pc=0x300 -> a later lookup of 0x300 gives pred_v_o=0; rptr unchanged.
- PRED_SIZE=8: allocate 0x1000..0x101C (step 4), then allocate 0x2000 -> entry 0 (tag 0x1000) replaced, rptr=1; lookup 0x1000 misses, 0x1004 still hits.
- Flush together with update of 0x400 taken -> all lookups miss afterwards; 0x400 not allocated; the next allocation lands in entry 0.
- Same-cycle update 0x500→0x600 taken plus lookup 0x500 -> pred_v_o=0 without PRED_BYPASS_EN; pred_v_o=1, pc_pred_o=0x600 with it.
